// File: rtl/audio_dac_serializer.sv
// I2S DAC transmitter: buffers stereo pairs in a small FIFO and shifts them out
// MSB-first on falling edges of the asynchronous codec bit clock.
`timescale 1ns/1ps
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  bclk,
  input  logic                  lrck,
  output logic                  dacdat,
  output logic                  underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  logic                  bclk_meta_q, bclk_meta_d, bclk_sync_q, bclk_sync_d;
  logic                  bclk_prev_q, bclk_prev_d;
  logic                  lrck_meta_q, lrck_meta_d, lrck_sync_q, lrck_sync_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, right_hold_q, right_hold_d;
  logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  dacdat_q, dacdat_d, underflow_q, underflow_d;

  logic [DATA_WIDTH-1:0] mem_left_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_right_q [FIFO_DEPTH];

  logic fe, lr_trans, to_left, to_right, fifo_empty, push, pop;

  assign write_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign dacdat      = dacdat_q;
  assign underflow   = underflow_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    bclk_meta_d  = bclk;
    bclk_sync_d  = bclk_meta_q;
    bclk_prev_d  = bclk_sync_q;
    lrck_meta_d  = lrck;
    lrck_sync_d  = lrck_meta_q;
    lrck_prev_d  = lrck_prev_q;
    shreg_d      = shreg_q;
    right_hold_d = right_hold_q;
    bitcnt_d     = bitcnt_q;
    dacdat_d     = dacdat_q;

    fe         = bclk_prev_q & ~bclk_sync_q;
    lr_trans   = fe & (lrck_sync_q != lrck_prev_q);
    to_left    = lr_trans & ~lrck_sync_q;
    to_right   = lr_trans & lrck_sync_q;
    fifo_empty = (count_q == '0);
    push       = write & write_ready;
    pop        = to_left & ~fifo_empty;

    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    underflow_d = to_left & fifo_empty;

    if (fe) lrck_prev_d = lrck_sync_q;

    // A transition always wins over remaining bits, so short frames are truncated.
    if (to_left) begin
      shreg_d      = pop ? mem_left_q[rd_ptr_q]  : '0;
      right_hold_d = pop ? mem_right_q[rd_ptr_q] : '0;
      bitcnt_d     = BIT_W'(DATA_WIDTH);
      dacdat_d     = 1'b0;
    end else if (to_right) begin
      shreg_d  = right_hold_q;
      bitcnt_d = BIT_W'(DATA_WIDTH);
      dacdat_d = 1'b0;
    end else if (fe) begin
      if (bitcnt_q != '0) begin
        dacdat_d = shreg_q[DATA_WIDTH-1];
        shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q - BIT_W'(1);
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_meta_q  <= 1'b0;
      bclk_sync_q  <= 1'b0;
      bclk_prev_q  <= 1'b0;
      lrck_meta_q  <= 1'b0;
      lrck_sync_q  <= 1'b0;
      lrck_prev_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      shreg_q      <= '0;
      right_hold_q <= '0;
      bitcnt_q     <= '0;
      dacdat_q     <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      bclk_meta_q  <= bclk_meta_d;
      bclk_sync_q  <= bclk_sync_d;
      bclk_prev_q  <= bclk_prev_d;
      lrck_meta_q  <= lrck_meta_d;
      lrck_sync_q  <= lrck_sync_d;
      lrck_prev_q  <= lrck_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      right_hold_q <= right_hold_d;
      bitcnt_q     <= bitcnt_d;
      dacdat_q     <= dacdat_d;
      underflow_q  <= underflow_d;
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_left_q[wr_ptr_q]  <= writedata_left;
      mem_right_q[wr_ptr_q] <= writedata_right;
    end
  end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
Transmit-side counterpart of the codec's ADC deserializer. Accepts parallel stereo sample pairs on the `write`/`write_ready` handshake used by the filter datapath and buffers them in a small FIFO. Serializes each sample MSB-first onto the DAC data line in I2S format, framed by the codec-supplied bit clock and left/right clock. All logic runs on the single system clock; `bclk` and `lrck` are sampled as asynchronous inputs.

Parameters:
DATA_WIDTH, 24, bits per channel sample
FIFO_DEPTH, 4, stereo pairs buffered (power of 2, ≥2)

Ports:
clk  input  1  system clock (50 MHz); all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
write  input  1  push one stereo pair; accepted only when write_ready=1
writedata_left  input  DATA_WIDTH  left sample, two's complement
writedata_right  input  DATA_WIDTH  right sample, two's complement
write_ready  output  1  FIFO not full
bclk  input  1  codec bit clock, asynchronous; frequency ≤ clk/8
lrck  input  1  codec DAC LR clock, asynchronous; 0 = left, 1 = right
dacdat  output  1  serial data to codec
underflow  output  1  one-clk pulse when a left frame starts with the FIFO empty

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, count=0, so write_ready=1.
  - dacdat=0, underflow=0.
  - Shift register, bit counter and right-hold register cleared.
  - Synchronizer flops and lrck_prev cleared to 0.
- Input synchronization and edge detection:
  - bclk and lrck each pass through 2-flop synchronizers.
  - A bclk falling edge (fe) is detected when the synchronized bclk goes from 1 to 0. All serial actions happen only on clk cycles where fe=1.
  - The lrck value is captured into lrck_prev on every fe. A transition is flagged when the synchronized lrck differs from lrck_prev at an fe.
- FIFO:
  - write_ready = (count != FIFO_DEPTH), combinational from count.
  - A push occurs on a cycle with write=1 and write_ready=1. A write while full is dropped with no other effect.
  - Push and pop in the same cycle: both take effect and count is unchanged.
  - When full, write_ready=0, so a push is not accepted that cycle even if a pop occurs.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Transition to left (synchronized lrck 1→0 at an fe):
  - If FIFO non-empty: pop one pair. Load the left sample into the shift register and the right sample into right_hold.
  - If FIFO empty: load 0 into both the shift register and right_hold, and pulse underflow for that clk cycle.
  - In both cases bitcnt = DATA_WIDTH.
- Transition to right (synchronized lrck 0→1 at an fe): load right_hold into the shift register, bitcnt = DATA_WIDTH. No FIFO access.
- Serial output (I2S one-bit delay):
  - On each fe that is not a transition, if bitcnt>0: dacdat <= shreg[MSB], shreg <<= 1, bitcnt--.
  - Otherwise dacdat <= 0.
  - On a transition fe, dacdat <= 0; the MSB appears on the fe after the transition.
  - dacdat changes only one clk after a detected fe. The codec samples it on the bclk rising edge.
- Short frame: if an lrck transition arrives with bitcnt>0, the remaining bits are abandoned and the new channel is loaded.
- Long frame: after DATA_WIDTH bits, dacdat is held at 0 until the next transition.
- Startup: right transitions occurring before the first left transition send right_hold=0.
- Reset mid-frame: outputs clear immediately. Serialization resumes at the first left transition after reset deasserts, and the pending pair is lost.
- Latency: a pair pushed at least 3 clk before a left-transition fe is output starting on the next fe.

Test Plan:
- Reset check: hold reset=0, then release with bclk/lrck toggling and no writes → write_ready=1, dacdat=0 throughout, underflow pulses once per left frame.
- Single pair: push L=0xA50F3C, R=0x123456 (bclk = clk/16, 32 bclk per channel), then one full lrck period → left bits 101001010000111100111100 MSB-first starting one bclk after lrck falls, followed by 8 zeros; right bits 000100100011010001010110 starting one bclk after lrck rises; underflow stays 0.
- Fill FIFO: push 5 pairs in consecutive cycles with no frame boundary → write_ready=0 after the 4th push, 5th pair dropped; then 4 frames output pairs 1–4 in order, and the 5th frame underflows with zeros.
- Push/pop collision: FIFO holds 2 pairs, write asserted on the exact cycle of a left-transition pop → count stays 2 and the pairs output in order.
- Underflow: empty FIFO at a left transition → one-clk underflow pulse, left and right both all zeros for that frame.
- Reset mid-frame: assert reset after 10 bits of left sample 0xFFFFFF → dacdat=0 within the same cycle, FIFO empty; after release with pair 0x000001/0x800000 pushed, output resumes at the next left frame with exactly those values.
